// File: rtl/cpu16_prefetch_if.sv
// ---------------------------------------------------------------------------
// cpu16_prefetch_if
// Bus bundle between the prefetch unit, instruction memory and decode.
//   MADDR  : fetch byte address (bit 0 always 0)
//   MREQ   : fetch request
//   MACK   : memory accept, MDATA valid in the same cycle
//   MDATA  : fetched big-endian word
//   IR/IPC : head instruction word and its byte address
//   IVALID : IR/IPC valid
//   IREADY : decode consumes the head word
//   REDIR  : one-cycle redirect strobe
//   RADDR  : redirect target byte address
// Modports: master = prefetch unit, slave = memory/decode side.
// ---------------------------------------------------------------------------
interface cpu16_prefetch_if;
    logic [15:0] MADDR;
    logic        MREQ;
    logic        MACK;
    logic [15:0] MDATA;
    logic [15:0] IR;
    logic [15:0] IPC;
    logic        IVALID;
    logic        IREADY;
    logic        REDIR;
    logic [15:0] RADDR;

    modport master (
        output MADDR, MREQ, IR, IPC, IVALID,
        input  MACK, MDATA, IREADY, REDIR, RADDR
    );

    modport slave (
        input  MADDR, MREQ, IR, IPC, IVALID,
        output MACK, MDATA, IREADY, REDIR, RADDR
    );
endinterface

// File: rtl/cpu16_prefetch.sv
// ---------------------------------------------------------------------------
// cpu16_prefetch
// Instruction prefetch unit: fetches 16-bit words from instruction memory
// into a DEPTH-entry queue of {word, address} pairs and presents the head
// entry to decode.
// Ports:
//   CK    : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : cpu16_prefetch_if.master (memory fetch, decode handoff, redirect)
// Parameters:
//   DEPTH    : queue entries, power of 2 in 2..16
//   RESET_PC : first fetch address after reset (bit 0 ignored)
// Optional build macro:
//   CPU16_PREFETCH_BYPASS_EN : when the queue is empty, an accepted word is
//   shown on IR/IPC in the same cycle; if decode takes it, it is not stored.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_START | one idle cycle after reset, no request
// S_FETCH | requesting words, pushing on MACK
// S_FULL  | queue holds DEPTH entries, request paused
// ---------------------------------------------------------------------------
module cpu16_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic              CK,
    input logic              RST_N,
    cpu16_prefetch_if.master bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {S_START, S_FETCH, S_FULL} state_t;

    state_t          state;
    state_t          state_next;
    logic [15:0]     pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [15:0]     q_word [DEPTH];
    logic [15:0]     q_addr [DEPTH];
    logic            mreq;
    logic            accept;
    logic            store;
    logic            fifo_pop;
    logic            not_empty;

    assign bus.MADDR = pc & 16'hFFFE;
    assign bus.MREQ  = mreq;
    assign not_empty = (count != '0);
    assign accept    = mreq & bus.MACK;

`ifdef CPU16_PREFETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = ~not_empty & accept;
    // A bypassed word taken by decode never enters the queue.
    assign store      = accept & ~bus.REDIR & ~(bypass_hit & bus.IREADY);
    assign bus.IVALID = not_empty | bypass_hit;
    assign bus.IR     = not_empty  ? q_word[rd_ptr] :
                        bypass_hit ? bus.MDATA      : 16'h0000;
    assign bus.IPC    = not_empty  ? q_addr[rd_ptr] :
                        bypass_hit ? bus.MADDR      : 16'h0000;
`else
    assign store      = accept & ~bus.REDIR;
    assign bus.IVALID = not_empty;
    assign bus.IR     = not_empty ? q_word[rd_ptr] : 16'h0000;
    assign bus.IPC    = not_empty ? q_addr[rd_ptr] : 16'h0000;
`endif

    assign fifo_pop   = not_empty & bus.IREADY & ~bus.REDIR;
    assign count_next = bus.REDIR ? '0 : (count + CW'(store) - CW'(fifo_pop));

    // State register
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_START;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_START: state_next = S_FETCH;
            S_FETCH: if (count_next == FULL_CNT) state_next = S_FULL;
            S_FULL:  if (count_next < FULL_CNT)  state_next = S_FETCH;
            default: state_next = S_START;
        endcase
        if (bus.REDIR) begin
            state_next = S_FETCH;
        end
    end

    // Output logic
    always_comb begin
        mreq = (state == S_FETCH);
    end

    // PC, pointers and occupancy
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            pc     <= RESET_PC & 16'hFFFE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.REDIR) begin
            pc     <= bus.RADDR & 16'hFFFE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // pc advances on every accepted word, bypassed or stored;
            // 16-bit arithmetic wraps FFFE -> 0000.
            if (accept) begin
                pc <= pc + 16'd2;
            end
            if (store) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

    // Queue storage needs no reset: entries are masked by count.
    always_ff @(posedge CK) begin
        if (store) begin
            q_word[wr_ptr] <= bus.MDATA;
            q_addr[wr_ptr] <= bus.MADDR;
        end
    end

endmodule

// File: tb/tb_cpu16_prefetch.sv
module tb_cpu16_prefetch;

    localparam int DEPTH = 4;

    logic CK    = 1'b0;
    logic RST_N = 1'b0;

    cpu16_prefetch_if bus();

    cpu16_prefetch #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .CK    (CK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CK = ~CK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] word;
        logic [15:0] addr;
    } entry_t;

    entry_t      mq[$];
    logic [15:0] m_pc;
    bit          m_started;

    logic        e_ivalid, e_mreq, e_bypass;
    logic [15:0] e_ir, e_ipc, e_maddr;

    typedef struct {
        bit          iready;
        bit          mack;
        logic        ivalid;
        logic        mreq;
        logic [15:0] ir;
        logic [15:0] ipc;
        logic [15:0] maddr;
    } vec_t;

    vec_t tv[6];

    function automatic logic [15:0] memf(input logic [15:0] a);
        case (a)
            16'h0000: memf = 16'h01A3;
            16'h0002: memf = 16'h0520;
            16'h0004: memf = 16'h0CCA;
            16'h0006: memf = 16'h08EB;
            default:  memf = a ^ 16'h5A5A;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = 16'h0000;
        m_started = 1'b0;
    endtask

    // Reference: a request is outstanding whenever the unit has left the
    // post-reset idle cycle and the queue has room.
    task automatic model_expect();
        e_mreq   = m_started && (mq.size() < DEPTH);
        e_maddr  = m_pc;
        e_bypass = 1'b0;
        if (mq.size() != 0) begin
            e_ivalid = 1'b1;
            e_ir     = mq[0].word;
            e_ipc    = mq[0].addr;
        end else begin
            e_ivalid = 1'b0;
            e_ir     = 16'h0000;
            e_ipc    = 16'h0000;
`ifdef CPU16_PREFETCH_BYPASS_EN
            if (e_mreq && bus.MACK) begin
                e_ivalid = 1'b1;
                e_ir     = bus.MDATA;
                e_ipc    = m_pc;
                e_bypass = 1'b1;
            end
`endif
        end
    endtask

    task automatic model_edge();
        entry_t e;
        if (bus.REDIR) begin
            mq.delete();
            m_pc = bus.RADDR & 16'hFFFE;
        end else begin
            if (mq.size() != 0 && bus.IREADY) void'(mq.pop_front());
            if (e_mreq && bus.MACK) begin
                if (!(e_bypass && bus.IREADY)) begin
                    e.word = bus.MDATA;
                    e.addr = m_pc;
                    mq.push_back(e);
                end
                m_pc = m_pc + 16'd2;
            end
        end
        m_started = 1'b1;
    endtask

    // Called at a falling edge: apply inputs, then compare mid-cycle.
    task automatic drive(input bit rdy, input bit ack, input bit rd, input logic [15:0] ra);
        bus.IREADY = rdy;
        bus.MACK   = ack;
        bus.REDIR  = rd;
        bus.RADDR  = ra;
        bus.MDATA  = memf(bus.MADDR);
        #1;
        model_expect();
        chk("ivalid", {15'd0, bus.IVALID}, {15'd0, e_ivalid});
        chk("ir",     bus.IR,    e_ir);
        chk("ipc",    bus.IPC,   e_ipc);
        chk("mreq",   {15'd0, bus.MREQ}, {15'd0, e_mreq});
        chk("maddr",  bus.MADDR, e_maddr);
    endtask

    task automatic advance();
        @(posedge CK);
        model_edge();
        @(negedge CK);
    endtask

    task automatic do_reset();
        RST_N      = 1'b0;
        bus.MACK   = 1'b1;
        bus.REDIR  = 1'b0;
        bus.IREADY = 1'b0;
        model_reset();
        #1;
        chk("rst_mreq",   {15'd0, bus.MREQ},   16'd0);
        chk("rst_ivalid", {15'd0, bus.IVALID}, 16'd0);
        repeat (2) @(negedge CK);
        RST_N = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushes;
        int rdy_pct;
        bus.MACK   = 1'b0;
        bus.MDATA  = 16'h0000;
        bus.IREADY = 1'b0;
        bus.REDIR  = 1'b0;
        bus.RADDR  = 16'h0000;

        // Streaming fetch from reset, MACK and IREADY always high.
        tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
`ifdef CPU16_PREFETCH_BYPASS_EN
        tv[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h01A3, 16'h0000, 16'h0000};
        tv[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0520, 16'h0002, 16'h0002};
        tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0CCA, 16'h0004, 16'h0004};
        tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h08EB, 16'h0006, 16'h0006};
        tv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h5A52, 16'h0008, 16'h0008};
`else
        tv[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
        tv[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h01A3, 16'h0000, 16'h0002};
        tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0520, 16'h0002, 16'h0004};
        tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0CCA, 16'h0004, 16'h0006};
        tv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h08EB, 16'h0006, 16'h0008};
`endif

        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(tv[i].iready, tv[i].mack, 1'b0, 16'h0000);
            chk("tv_ivalid", {15'd0, bus.IVALID}, {15'd0, tv[i].ivalid});
            chk("tv_mreq",   {15'd0, bus.MREQ},   {15'd0, tv[i].mreq});
            chk("tv_ir",     bus.IR,    tv[i].ir);
            chk("tv_ipc",    bus.IPC,   tv[i].ipc);
            chk("tv_maddr",  bus.MADDR, tv[i].maddr);
            advance();
        end

        // Fill with decode stalled, then one consume reopens fetch.
        do_reset();
        pushes = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0000);
            if (bus.MREQ === 1'b1) pushes++;
            advance();
        end
        chk("full_pushes", 16'(pushes), 16'd4);
        drive(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("full_mreq", {15'd0, bus.MREQ}, 16'd0);
        chk("full_ir",   bus.IR, 16'h01A3);
        advance();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("reopen_ir",   bus.IR, 16'h0520);
        chk("reopen_mreq", {15'd0, bus.MREQ}, 16'd1);
        advance();

        // Memory stalls three cycles at 0004.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 16'h0000); advance();
        drive(1'b0, 1'b1, 1'b0, 16'h0000); advance();
        drive(1'b0, 1'b1, 1'b0, 16'h0000); advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0000);
            chk("stall_maddr", bus.MADDR, 16'h0004);
            chk("stall_mreq",  {15'd0, bus.MREQ}, 16'd1);
            advance();
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("stall_ack_maddr", bus.MADDR, 16'h0004);
        advance();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("stall_next_maddr", bus.MADDR, 16'h0006);
        chk("stall_pop0", bus.IR, 16'h01A3);
        advance();
        drive(1'b1, 1'b0, 1'b0, 16'h0000); chk("stall_pop1", bus.IR, 16'h0520); advance();
        drive(1'b1, 1'b0, 1'b0, 16'h0000); chk("stall_pop2", bus.IR, 16'h0CCA); advance();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("stall_one_push", {15'd0, bus.IVALID}, 16'd0);
        advance();

        // Redirect with three entries queued; same-cycle ack and pop dropped.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 16'h0000); advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0000); advance();
        end
        drive(1'b1, 1'b1, 1'b1, 16'h0031);
        chk("redir_pre_ir", bus.IR, 16'h01A3);
        advance();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("redir_ivalid", {15'd0, bus.IVALID}, 16'd0);
        chk("redir_maddr",  bus.MADDR, 16'h0030);
        advance();
        drive(1'b0, 1'b1, 1'b0, 16'h0000); advance();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("redir_ipc", bus.IPC, 16'h0030);
        chk("redir_ir",  bus.IR,  16'h5A6A);
        advance();

        // PC wrap at FFFE.
        drive(1'b1, 1'b0, 1'b1, 16'hFFFF); advance();
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("wrap_pre", bus.MADDR, 16'hFFFE);
        advance();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("wrap_maddr", bus.MADDR, 16'h0000);
        chk("wrap_ipc",   bus.IPC,   16'hFFFE);

        // Asynchronous reset in the middle of a fetch cycle.
        bus.MACK = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_mreq",   {15'd0, bus.MREQ},   16'd0);
        chk("async_ivalid", {15'd0, bus.IVALID}, 16'd0);
        chk("async_ir",     bus.IR,    16'h0000);
        chk("async_ipc",    bus.IPC,   16'h0000);
        chk("async_maddr",  bus.MADDR, 16'h0000);
        model_reset();
        repeat (2) @(negedge CK);
        RST_N = 1'b1;

        // Randomised traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            rdy_pct = ((i / 300) % 2 == 0) ? 80 : 20;
            if (i == 1500) do_reset();
            drive($urandom_range(0, 99) < rdy_pct,
                  $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 3,
                  16'($urandom));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu16_prefetch.md
CPU16_PREFETCH -- requirements
Module: cpu16_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue entries; power of 2, range 2..16.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset; bit 0 ignored.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port CK  input  1  clock; all state updates on rising edge.
REQ-005 Port RST_N  input  1  asynchronous active-low reset.
REQ-006 Port MADDR  output  16  fetch byte address to instruction memory; bit 0 always 0.
REQ-007 Port MREQ  output  1  fetch request to memory.
REQ-008 Port MACK  input  1  memory accept; MDATA valid in the same cycle.
REQ-009 Port MDATA  input  16  fetched word, big-endian byte pair {mem[A], mem[A+1]}.
REQ-010 Port IR  output  16  instruction word presented to decode.
REQ-011 Port IPC  output  16  byte address of the word on IR.
REQ-012 Port IVALID  output  1  IR/IPC hold a valid instruction.
REQ-013 Port IREADY  input  1  decode consumes the head word this cycle.
REQ-014 Port REDIR  input  1  one-cycle redirect strobe: flush and refetch from RADDR.
REQ-015 Port RADDR  input  16  redirect target byte address.

Function
REQ-016 SHALL hold a fetch PC and a DEPTH-entry FIFO of {word, address} pairs with a count register (0..DEPTH).
REQ-017 SHALL drive MADDR = {pc[15:1], 1'b0} continuously.
REQ-018 SHALL use FSM states S_START, S_FETCH and S_FULL; reset state is S_START.
REQ-019 S_START: MREQ=0; unconditional transition to S_FETCH on the next edge.
REQ-020 S_FETCH: MREQ=1; on MACK=1 the {MDATA, MADDR} pair is pushed and pc increments by 2; the FSM moves to S_FULL when the post-edge count equals DEPTH.
REQ-021 S_FULL: MREQ=0; the FSM returns to S_FETCH on the edge where count drops below DEPTH.
REQ-022 MADDR SHALL stay stable while MREQ=1 and MACK=0, except on REDIR.
REQ-023 A pop SHALL occur when IVALID=1 and IREADY=1; IR/IPC then advance to the next entry.
REQ-024 IVALID SHALL be (count != 0); IR and IPC SHALL equal the head entry; both SHALL hold 0 when empty.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged; this holds at count=DEPTH-1 and at count=1.
REQ-026 MACK while MREQ=0 SHALL be ignored.
REQ-027 pc SHALL wrap from 16'hFFFE to 16'h0000; FIFO pointers SHALL wrap modulo DEPTH.
REQ-028 Push latency: a word accepted on MACK at edge N SHALL appear on IR with IVALID=1 after edge N.
REQ-029 REDIR=1 SHALL, at the next edge, empty the FIFO, set pc = {RADDR[15:1], 0} and enter S_FETCH.
REQ-030 Under REDIR, a same-cycle MACK word and a same-cycle pop SHALL be discarded with no effect.
REQ-031 While REDIR=1, MREQ SHALL still follow the current state; memory samples MADDR only in MACK cycles.

Reset
REQ-032 RST_N=0 SHALL immediately force the following, independent of CK: state S_START, pc=RESET_PC with bit 0 cleared, count=0, FIFO pointers=0, MREQ=0, IVALID=0, IR=0, IPC=0.
REQ-033 Reset mid-request SHALL abandon the outstanding request; MACK during reset SHALL be ignored.
REQ-034 The first MREQ=1 SHALL occur in the second cycle after RST_N deasserts.

Configuration
REQ-035 Macro CPU16_PREFETCH_BYPASS_EN SHALL, when defined, enable a zero-latency bypass.
REQ-036 With the bypass and count=0, MACK=1 SHALL drive IR=MDATA, IPC=MADDR and IVALID=1 in the same cycle; if IREADY=1 too, the word SHALL NOT be stored.
REQ-037 Without the macro, IVALID SHALL depend only on registered state, and latency SHALL be per REQ-028.

Verification
REQ-038 Reset release; memory holds 01A3,0520,0CCA,08EB at 0..6; MACK=1 always; IREADY=1 -> IR sequence 01A3,0520,0CCA,08EB; IPC 0,2,4,6; MADDR steps by 2.
REQ-039 IREADY=0, DEPTH=4 -> exactly 4 pushes, then MREQ=0 and state S_FULL; one IREADY pulse -> IR=0520 and MREQ=1 the next cycle.
REQ-040 MACK delayed 3 cycles -> MADDR held at 0004 throughout; exactly one push occurs.
REQ-041 REDIR=1 with RADDR=0031 and count=3 -> the next cycle has IVALID=0 and MADDR=0030; the first IPC after that is 0030.
REQ-042 pc=FFFE after MACK -> MADDR=0000; RST_N low mid-fetch -> MREQ=0 and IVALID=0 immediately.
REQ-043 Build with CPU16_PREFETCH_BYPASS_EN, queue empty, MACK=1 with MDATA=0A13 -> IR=0A13 and IVALID=1 in the same cycle; count stays 0 when IREADY=1.
